// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: fetch FSM states, NOP encoding and PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack port and fills the IF/ID register.
// Optional FETCH_PERF_EN adds fetch_cnt / redirect_cnt event counters.
module if_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = fetch_pkg::NOP_INST
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  use_branch,
   input  logic [ADDR_WIDTH-1:0] branch_out,
   input  logic                  flush,
   input  logic                  stall,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_inst,
   output logic                  if_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           fetch_cnt,
   output logic [31:0]           redirect_cnt
`endif
);

   import fetch_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2'b11);

   fetch_state_e          state_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [DATA_WIDTH-1:0] hold_r;
   logic                  slot_free_s;
   logic [ADDR_WIDTH-1:0] pc_next_s;
   logic [ADDR_WIDTH-1:0] target_s;

   // Derived next-PC, aligned redirect target and IF/ID availability
   always_comb begin
      slot_free_s = !if_valid || !stall;
      pc_next_s   = pc_r + ADDR_WIDTH'(PC_STEP);
      target_s    = branch_out & ALIGN_MASK;
   end

   // Fetch FSM, PC, hold buffer and IF/ID register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         pc_r     <= PC_ADDR;
         hold_r   <= {DATA_WIDTH{1'b0}};
         mem_req  <= 1'b0;
         mem_addr <= PC_ADDR;
         if_pc    <= PC_ADDR;
         if_inst  <= NOP_INST;
         if_valid <= 1'b0;
      end else if (use_branch) begin
         pc_r     <= target_s;
         hold_r   <= {DATA_WIDTH{1'b0}};
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
         case (state_r)
            // An in-flight transaction must complete; only a finished one can be retargeted
            REQ, KILL: begin
               if (mem_ack) begin
                  state_r  <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= target_s;
               end else begin
                  state_r  <= KILL;
               end
            end
            IDLE, HOLD: begin
               state_r  <= REQ;
               mem_req  <= 1'b1;
               mem_addr <= target_s;
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end else begin
         if (flush) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
         end
         case (state_r)
            IDLE: begin
               state_r  <= REQ;
               mem_req  <= 1'b1;
               mem_addr <= pc_r;
            end
            REQ: begin
               if (mem_ack) begin
                  if (slot_free_s) begin
                     if (!flush) begin
                        if_pc    <= pc_r;
                        if_inst  <= mem_rdata;
                        if_valid <= 1'b1;
                     end
                     pc_r     <= pc_next_s;
                     mem_addr <= pc_next_s;
                  end else begin
                     hold_r  <= mem_rdata;
                     mem_req <= 1'b0;
                     state_r <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  if (!flush) begin
                     if_pc    <= pc_r;
                     if_inst  <= hold_r;
                     if_valid <= 1'b1;
                  end
                  pc_r     <= pc_next_s;
                  mem_req  <= 1'b1;
                  mem_addr <= pc_next_s;
                  state_r  <= REQ;
               end
            end
            KILL: begin
               if (mem_ack) begin
                  mem_req  <= 1'b1;
                  mem_addr <= pc_r;
                  state_r  <= REQ;
               end
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic deliver_s;

   // An instruction reaches IF/ID only when not redirected or flushed in the same cycle
   always_comb begin
      if (use_branch || flush) begin
         deliver_s = 1'b0;
      end else begin
         deliver_s = ((state_r == REQ) && mem_ack && slot_free_s) ||
                     ((state_r == HOLD) && !stall);
      end
   end

   // Event counters, free-running with natural wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt    <= 32'd0;
         redirect_cnt <= 32'd0;
      end else begin
         if (deliver_s) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (use_branch) begin
            redirect_cnt <= redirect_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
